// File: rtl/g_round_sched.sv
// Round scheduler for the pipelined BLAKE3 round engine. Jobs are injected, recirculated
// through the engine NUM_ROUNDS times with the message permutation between rounds, then retired.
module g_round_sched #(
  parameter int NUM_ROUNDS = 7,
  parameter int ROUND_LAT  = 10,
  parameter int TAG_W      = 8,
  parameter int CNT_W      = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Job_Valid_I,
  output logic             Job_Ready_O,
  input  logic [511:0]     Job_V_I,
  input  logic [511:0]     Job_M_I,
  input  logic [TAG_W-1:0] Job_Tag_I,
  output logic [511:0]     Eng_V_O,
  output logic [511:0]     Eng_M_O,
  input  logic [511:0]     Eng_V_I,
  output logic             Res_Valid_O,
  output logic [255:0]     Res_H_O,
  output logic [TAG_W-1:0] Res_Tag_O,
  output logic [CNT_W-1:0] In_Flight_O,
  output logic             Idle_O
);
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(NUM_ROUNDS - 1);
  localparam int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  // Stage 0 is the issue register's side state; stage ROUND_LAT-1 is the tap that
  // describes the engine output currently on Eng_V_I.
  logic [ROUND_LAT-1:0]            vld_pipe;
  logic [ROUND_LAT-1:0][RW-1:0]    r_pipe;
  logic [ROUND_LAT-1:0][TAG_W-1:0] tag_pipe;

  logic             tap_vld, recirc, retire, accept;
  logic [RW-1:0]    tap_r;
  logic [TAG_W-1:0] tap_tag;
  logic [511:0]     tap_m, rec_m;
  logic [255:0]     fold;

  assign tap_vld     = vld_pipe[ROUND_LAT-1];
  assign tap_r       = r_pipe[ROUND_LAT-1];
  assign tap_tag     = tag_pipe[ROUND_LAT-1];
  assign recirc      = tap_vld && (tap_r < LAST_R);
  assign retire      = tap_vld && !(tap_r < LAST_R);
  assign Job_Ready_O = !recirc;
  assign accept      = Job_Valid_I && !recirc;
  assign Idle_O      = (In_Flight_O == '0);

  // The issued message rides alongside the engine; Eng_M_O itself is stage 0.
  if (ROUND_LAT == 1) begin : g_tap_direct
    assign tap_m = Eng_M_O;
  end else begin : g_tap_dly
    logic [ROUND_LAT-1:1][511:0] m_dly;
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        m_dly <= '0;
      end else begin
        m_dly[1] <= Eng_M_O;
        for (int k = 2; k < ROUND_LAT; k++) m_dly[k] <= m_dly[k-1];
      end
    end
    assign tap_m = m_dly[ROUND_LAT-1];
  end

  for (genvar i = 0; i < 16; i++) begin : g_perm
    assign rec_m[32*i +: 32] = tap_m[32*PERM[i] +: 32];
  end

  for (genvar i = 0; i < 8; i++) begin : g_fold
    assign fold[32*i +: 32] = Eng_V_I[32*i +: 32] ^ Eng_V_I[32*(i+8) +: 32];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_pipe <= '0;
      r_pipe   <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept || recirc;
      r_pipe[0]   <= recirc ? RW'(tap_r + 1'b1) : '0;
      tag_pipe[0] <= recirc ? tap_tag : Job_Tag_I;
      for (int k = 1; k < ROUND_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        r_pipe[k]   <= r_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // Idle slots leave the issue register untouched; the engine churns on stale data.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Eng_V_O <= '0;
      Eng_M_O <= '0;
    end else if (recirc) begin
      Eng_V_O <= Eng_V_I;
      Eng_M_O <= rec_m;
    end else if (accept) begin
      Eng_V_O <= Job_V_I;
      Eng_M_O <= Job_M_I;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Res_Valid_O <= 1'b0;
      Res_H_O     <= '0;
      Res_Tag_O   <= '0;
    end else begin
      Res_Valid_O <= retire;
      if (retire) begin
        Res_H_O   <= fold;
        Res_Tag_O <= tap_tag;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      In_Flight_O <= '0;
    end else if (accept && !retire) begin
      In_Flight_O <= In_Flight_O + 1'b1;
    end else if (retire && !accept) begin
      In_Flight_O <= In_Flight_O - 1'b1;
    end
  end
endmodule

// File: tb/tb_g_round_sched.sv
// Directed bench for g_round_sched: behavioural BLAKE3 round engines plus a cycle-level
// scoreboard of accept cycles that predicts ready, in-flight count and result pulses.
module tb_g_round_sched;
  localparam int L = 10, N = 7, TW = 8, CW = 5;
  localparam int P [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic job_valid = 1'b0, job_ready;
  logic [511:0] job_v = '0, job_m = '0, eng_v_o, eng_m_o, eng_v_i;
  logic [TW-1:0] job_tag = '0, res_tag;
  logic res_valid, idle;
  logic [255:0] res_h;
  logic [CW-1:0] in_flight;

  logic b_valid = 1'b0, b_ready, b_res_valid, b_idle;
  logic [511:0] b_v = '0, b_m = '0, b_eng_v_o, b_eng_m_o, b_eng_v_i;
  logic [TW-1:0] b_tag = '0, b_res_tag;
  logic [255:0] b_res_h;
  logic [CW-1:0] b_in_flight;

  g_round_sched #(.NUM_ROUNDS(N), .ROUND_LAT(L), .TAG_W(TW), .CNT_W(CW)) dut (
    .Clk(clk), .Rst(rst), .Job_Valid_I(job_valid), .Job_Ready_O(job_ready),
    .Job_V_I(job_v), .Job_M_I(job_m), .Job_Tag_I(job_tag),
    .Eng_V_O(eng_v_o), .Eng_M_O(eng_m_o), .Eng_V_I(eng_v_i),
    .Res_Valid_O(res_valid), .Res_H_O(res_h), .Res_Tag_O(res_tag),
    .In_Flight_O(in_flight), .Idle_O(idle));

  g_round_sched #(.NUM_ROUNDS(2), .ROUND_LAT(L), .TAG_W(TW), .CNT_W(CW)) dut2 (
    .Clk(clk), .Rst(rst), .Job_Valid_I(b_valid), .Job_Ready_O(b_ready),
    .Job_V_I(b_v), .Job_M_I(b_m), .Job_Tag_I(b_tag),
    .Eng_V_O(b_eng_v_o), .Eng_M_O(b_eng_m_o), .Eng_V_I(b_eng_v_i),
    .Res_Valid_O(b_res_valid), .Res_H_O(b_res_h), .Res_Tag_O(b_res_tag),
    .In_Flight_O(b_in_flight), .Idle_O(b_idle));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] gf(input logic [31:0] a0, b0, c0, d0, x, y);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b + x; d = ror(d ^ a, 16); c = c + d; b = ror(b ^ c, 12);
    a = a + b + y; d = ror(d ^ a, 8);  c = c + d; b = ror(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] round_fn(input logic [511:0] v, input logic [511:0] m);
    logic [31:0] s [16];
    logic [31:0] w [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) begin s[i] = v[32*i +: 32]; w[i] = m[32*i +: 32]; end
    {s[0], s[4], s[8],  s[12]} = gf(s[0], s[4], s[8],  s[12], w[0],  w[1]);
    {s[1], s[5], s[9],  s[13]} = gf(s[1], s[5], s[9],  s[13], w[2],  w[3]);
    {s[2], s[6], s[10], s[14]} = gf(s[2], s[6], s[10], s[14], w[4],  w[5]);
    {s[3], s[7], s[11], s[15]} = gf(s[3], s[7], s[11], s[15], w[6],  w[7]);
    {s[0], s[5], s[10], s[15]} = gf(s[0], s[5], s[10], s[15], w[8],  w[9]);
    {s[1], s[6], s[11], s[12]} = gf(s[1], s[6], s[11], s[12], w[10], w[11]);
    {s[2], s[7], s[8],  s[13]} = gf(s[2], s[7], s[8],  s[13], w[12], w[13]);
    {s[3], s[4], s[9],  s[14]} = gf(s[3], s[4], s[9],  s[14], w[14], w[15]);
    for (int i = 0; i < 16; i++) o[32*i +: 32] = s[i];
    return o;
  endfunction

  function automatic logic [511:0] perm_fn(input logic [511:0] m);
    logic [511:0] o;
    for (int i = 0; i < 16; i++) o[32*i +: 32] = m[32*P[i] +: 32];
    return o;
  endfunction

  function automatic logic [255:0] compress(input logic [511:0] v, input logic [511:0] m, input int nr);
    logic [511:0] s, mm;
    logic [255:0] h;
    s = v; mm = m;
    for (int r = 0; r < nr; r++) begin s = round_fn(s, mm); mm = perm_fn(mm); end
    for (int i = 0; i < 8; i++) h[32*i +: 32] = s[32*i +: 32] ^ s[32*(i+8) +: 32];
    return h;
  endfunction

  function automatic logic [511:0] b3_v(input logic [31:0] len);
    logic [511:0] v;
    logic [31:0] iv [8];
    iv = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    for (int i = 0; i < 8; i++) v[32*i +: 32] = iv[i];
    for (int i = 0; i < 4; i++) v[32*(i+8) +: 32] = iv[i];
    v[32*12 +: 32] = '0; v[32*13 +: 32] = '0;
    v[32*14 +: 32] = len; v[32*15 +: 32] = 32'h0000000B;
    return v;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Behavioural engines: round function then ROUND_LAT-1 registers back to Eng_V_I.
  logic [511:0] e1 [L-1];
  logic [511:0] e2 [L-1];
  always @(posedge clk) begin
    e1[0] <= round_fn(eng_v_o, eng_m_o);
    e2[0] <= round_fn(b_eng_v_o, b_eng_m_o);
    for (int k = 1; k < L - 1; k++) begin e1[k] <= e1[k-1]; e2[k] <= e2[k-1]; end
  end
  assign eng_v_i   = e1[L-2];
  assign b_eng_v_i = e2[L-2];

  int ncmp = 0, nerr = 0;
  int acc_c [$];
  logic [TW-1:0] acc_t [$];
  logic [255:0] acc_h [$];
  bit acc_live [$];
  logic [TW-1:0] last_tag = '0;
  logic [255:0] last_h = '0;
  bit m_rdy;
  int mx_if = 0;

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit rv;
    int nif, d;
    rv = 1'b0; nif = 0; m_rdy = 1'b1;
    foreach (acc_c[j]) if (acc_live[j]) begin
      d = cyc - acc_c[j];
      if (d >= 1 && d <= N*L) nif++;
      if (d == N*L + 1) begin rv = 1'b1; last_tag = acc_t[j]; last_h = acc_h[j]; end
      if (d > 0 && d % L == 0 && d / L <= N - 1) m_rdy = 1'b0;
    end
    if (int'(in_flight) > mx_if) mx_if = int'(in_flight);
    chk("res_valid", res_valid, rv);
    chk("in_flight", in_flight, nif);
    chk("idle", idle, nif == 0);
    chk("job_ready", job_ready, m_rdy);
    chk("res_tag", res_tag, last_tag);
    chk("res_h", res_h, last_h);
  endtask

  task automatic tick(input bit val, input logic [TW-1:0] tag, input logic [511:0] v, m,
                      input logic [255:0] h, output bit took);
    @(negedge clk);
    check_cycle();
    job_valid = val; job_tag = tag; job_v = v; job_m = m;
    took = val && m_rdy;
    if (took) begin acc_c.push_back(cyc); acc_t.push_back(tag); acc_h.push_back(h); acc_live.push_back(1'b1); end
    @(posedge clk);
  endtask

  task automatic idle_n(input int n);
    bit t;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, '0, t);
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic [511:0] v, m, input logic [255:0] h);
    bit t;
    tick(1'b1, tag, v, m, h, t);
    chk("send_accepted", t, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    int sent, took_n;
    logic [511:0] v, m, pe;
    logic [255:0] h;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_ready", job_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_inflight", in_flight, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_eng_v", eng_v_o, '0);
    chk("rst_eng_m", eng_m_o, '0);
    chk("rst_res_h", res_h, '0);
    chk("rst_res_tag", res_tag, '0);

    // BLAKE3 block: IV, counter 0, len 64, flags 0x0B, zero message.
    send(8'h5A, b3_v(32'd64), '0, compress(b3_v(32'd64), '0, N));
    idle_n(75);

    // Empty-input BLAKE3 hash, expected value is the published digest.
    send(8'h33, b3_v(32'd0), '0,
         {32'h62321fe4, 32'hca939acc, 32'hb712c1ad, 32'hc925cb9b,
          32'h49c9dc36, 32'hea4d40a0, 32'ha6a1f9f5, 32'hb94913af});
    idle_n(75);

    // Ten back-to-back jobs fill every slot.
    took_n = 0;
    for (int i = 0; i < 10; i++) begin
      v = rnd512(); m = rnd512();
      tick(1'b1, TW'(i), v, m, compress(v, m, N), t);
      took_n += int'(t);
    end
    chk("b2b_accepted", took_n, 10);
    idle_n(75);

    // Continuous offer of 25 jobs.
    sent = 0; mx_if = 0;
    v = rnd512(); m = rnd512();
    for (int it = 0; it < 600 && sent < 25; it++) begin
      tick(1'b1, TW'(100 + sent), v, m, compress(v, m, N), t);
      if (t) begin sent++; v = rnd512(); m = rnd512(); end
    end
    chk("stream_sent", sent, 25);
    idle_n(75);
    chk("stream_max_inflight", mx_if, 10);

    // Second job offered on the first job's retiring cycle.
    v = rnd512(); m = rnd512();
    send(8'hA1, v, m, compress(v, m, N));
    idle_n(69);
    v = rnd512(); m = rnd512();
    send(8'hA2, v, m, compress(v, m, N));
    idle_n(75);

    // Permutation on the two-round instance.
    #1;
    b_v = rnd512();
    for (int i = 0; i < 16; i++) b_m[32*i +: 32] = i;
    for (int i = 0; i < 16; i++) pe[32*i +: 32] = P[i];
    b_tag = 8'hC7; b_valid = 1'b1;
    h = compress(b_v, b_m, 2);
    for (int k = 0; k < 22; k++) begin
      idle_n(1);
      #1;
      b_valid = 1'b0;
      if (k == 0) begin
        chk("perm_r0_m", b_eng_m_o, b_m);
        chk("perm_r0_inflight", b_in_flight, 1);
      end
      if (k == 9)  chk("perm_hold_m", b_eng_m_o, b_m);
      if (k == 10) chk("perm_r1_m", b_eng_m_o, pe);
      if (k == 19) chk("perm_res_early", b_res_valid, 1'b0);
      if (k == 20) begin
        chk("perm_res_valid", b_res_valid, 1'b1);
        chk("perm_res_h", b_res_h, h);
        chk("perm_res_tag", b_res_tag, 8'hC7);
        chk("perm_idle", b_idle, 1'b1);
      end
      if (k == 21) chk("perm_res_pulse", b_res_valid, 1'b0);
    end

    // Reset with four jobs in flight drops them.
    for (int i = 0; i < 4; i++) begin
      v = rnd512(); m = rnd512();
      send(TW'(200 + i), v, m, compress(v, m, N));
    end
    idle_n(5);
    @(negedge clk);
    job_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_inflight", in_flight, '0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_eng_v", eng_v_o, '0);
    chk("mid_rst_eng_m", eng_m_o, '0);
    chk("mid_rst_res_h", res_h, '0);
    chk("mid_rst_res_tag", res_tag, '0);
    foreach (acc_live[j]) acc_live[j] = 1'b0;
    last_tag = '0; last_h = '0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("post_rst_ready", job_ready, 1'b1);
    v = rnd512(); m = rnd512();
    send(8'hE5, v, m, compress(v, m, N));
    idle_n(75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/g_round_sched.md
Name: g_round_sched

Overview:
- Scheduler and sequencer for the fully pipelined single-round compression engine (column + diagonal G stages, fixed latency, no stall, no valid signal of its own).
- Accepts compression jobs (16-word state, 16-word message, tag) and injects them into the engine.
- Recirculates each job through the engine NUM_ROUNDS times, applying the BLAKE3 message permutation between rounds.
- Retires the finalized 8-word chaining value with its tag. Keeps the engine busy with up to ROUND_LAT interleaved jobs.

Parameters:
- NUM_ROUNDS, 7, rounds per compression (≥1)
- ROUND_LAT, 10, engine latency in cycles from Eng_V_O/Eng_M_O to the matching Eng_V_I (≥1)
- TAG_W, 8, job tag width
- CNT_W, 5, in-flight counter width (≥ clog2(ROUND_LAT+1))

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- Job_Valid_I  in  1  job offered
- Job_Ready_O  out  1  issue slot free this cycle
- Job_V_I  in  512  initial state v0..v15, word i at [32i+31:32i]
- Job_M_I  in  512  message m0..m15, same packing
- Job_Tag_I  in  TAG_W  job tag
- Eng_V_O  out  512  state to engine (registered)
- Eng_M_O  out  512  message to engine (registered)
- Eng_V_I  in  512  engine output state
- Res_Valid_O  out  1  result pulse, one cycle
- Res_H_O  out  256  h[i] = v[i] ^ v[i+8], i = 0..7
- Res_Tag_O  out  TAG_W  tag of the result
- In_Flight_O  out  CNT_W  jobs currently inside the engine
- Idle_O  out  1  In_Flight_O == 0

Behaviour:
- One issue slot per clock. The issue register (Eng_V_O, Eng_M_O, plus a side valid bit, round index r, and tag) loads on every edge.
- Side delay line, ROUND_LAT deep, carries valid, r, tag and issued message. Its tap is aligned so that tap contents always describe the current Eng_V_I.
- Return classification, at the tap, when tap valid:
  - Recirculating if r < NUM_ROUNDS-1.
  - Retiring otherwise.
- Arbitration: a recirculating return has absolute priority over new jobs.
  - Job_Ready_O = !(tap valid && recirculating). Combinational from the delay line only; no dependence on Job_Valid_I.
  - Job accepted on Job_Valid_I && Job_Ready_O: issue V = Job_V_I, M = Job_M_I (unpermuted), r = 0, tag = Job_Tag_I.
  - Recirculation: issue V = Eng_V_I, M = perm(returned M), r + 1, same tag.
  - perm: new m[i] = old m[P[i]], with P = 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8.
  - Neither case: issue valid = 0. Eng_V_O/Eng_M_O hold their previous values; the engine computes garbage that is ignored.
- Retire: on the edge after the retiring cycle, Res_Valid_O = 1, Res_H_O = XOR fold of Eng_V_I, Res_Tag_O = tag. Otherwise Res_Valid_O = 0.
  - Res_H_O and Res_Tag_O hold their last values.
  - No output backpressure; the consumer must accept every pulse.
  - A retiring cycle frees the slot, so a new job may be accepted in that same cycle.
- Latency: job accepted at edge k → Res_Valid_O high in the cycle after edge k + NUM_ROUNDS*ROUND_LAT + 1 (71 cycles at defaults). Independent of load.
- Ordering: results retire in acceptance order.
- Throughput: at most ROUND_LAT jobs in flight. With the pipe full, Job_Ready_O stays low until a retire.
- In_Flight_O:
  - +1 on accept, −1 on retire.
  - Accept and retire in the same cycle → unchanged.
  - Never exceeds ROUND_LAT and never underflows.
- Reset (any time, including mid-operation):
  - All delay-line and issue valid bits = 0, In_Flight_O = 0, Res_Valid_O = 0, Res_H_O = 0, Res_Tag_O = 0, Eng_V_O = 0, Eng_M_O = 0.
  - Idle_O = 1.
  - In-flight jobs are discarded with no result.
  - Job_Ready_O = 1 once Rst is deasserted.

Test Plan:
- Single job, BLAKE3 test vector (IV, counter 0, len 64, flags 0x0B, zero message), behavioural engine with ROUND_LAT=10 → one Res_Valid_O pulse exactly 71 cycles after accept with the reference chaining value and tag 0x5A; In_Flight_O goes 0→1→0.
- Back-to-back stream of 10 jobs, tags 0..9, Job_Valid_I held high → all accepted on consecutive cycles; Job_Ready_O low from cycle 10 until the first retire; results tags 0..9 on consecutive cycles, each with the correct hash.
- Continuous offer of 25 jobs → every Job_Ready_O low cycle coincides with a recirculating tap; In_Flight_O never exceeds 10; all 25 results correct and in order.
- Retire/accept collision: job offered exactly on a retiring cycle → accepted that cycle, In_Flight_O unchanged, both results correct.
- Permutation check: NUM_ROUNDS=2 with a single job, M = 0..15 → Eng_M_O for round 1 equals 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8.
- Rst asserted for 1 cycle with 4 jobs in flight → outputs zero immediately; no Res_Valid_O pulse for the dropped jobs; a new job after reset completes in 71 cycles with the correct hash.
